// File: rtl/gpio_bcd_display.sv
// 32-bit binary to eight active-low seven-segment digits through a one-bit-per-clock
// double-dabble engine. Define GPIO_BCD_LZB_EN to blank leading zeros.
module gpio_bcd_display #(
    parameter int NDIG = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        overflow,
    output logic        busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q;
    logic [31:0] last_q;
    logic [31:0] bin_q;
    logic [39:0] scr_q;
    logic [4:0]  cnt_q;
    logic [39:0] disp_q;

    logic [38:0] adj;
    logic [39:0] scr_next;

    // A 32-bit input never pushes the top digit past 4, so its adjusted MSB is dropped.
    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
        end
        adj[38:36] = (scr_q[39:36] >= 4'd5) ? 3'(scr_q[39:36] + 4'd3) : scr_q[38:36];
    end

    assign scr_next = {adj, bin_q[31]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (value != last_q) begin
                        last_q  <= value;
                        bin_q   <= value;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr_q <= scr_next;
                    bin_q <= {bin_q[30:0], 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        disp_q  <= scr_next;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = (state_q == SHIFT);
    assign overflow = (disp_q[39:32] != 8'd0);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [NDIG-1:0] blank;

`ifdef GPIO_BCD_LZB_EN
    logic zero_run;

    // Walk down from the top digit; a digit blanks while everything above it is zero.
    always_comb begin
        blank    = '0;
        zero_run = !overflow;
        for (int unsigned i = 0; i < NDIG - 1; i++) begin
            zero_run               = zero_run && (disp_q[4*(NDIG-1-i) +: 4] == 4'd0);
            blank[NDIG-1-i]        = zero_run;
        end
    end
`else
    assign blank = '0;
`endif

    logic [6:0] seg [NDIG];

    always_comb begin
        for (int unsigned i = 0; i < NDIG; i++) begin
            seg[i] = blank[i] ? 7'h7F : seg7(disp_q[4*i +: 4]);
        end
    end

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign hex4 = seg[4];
    assign hex5 = seg[5];
    assign hex6 = seg[6];
    assign hex7 = seg[7];

endmodule

// File: tb/tb_gpio_bcd_display.sv
// Scoreboard bench for gpio_bcd_display: stimulus queues expected displays, a monitor
// compares them on each busy falling edge. Honours GPIO_BCD_LZB_EN like the design.
module tb_gpio_bcd_display;

    logic        clk;
    logic        rst;
    logic [31:0] value;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        overflow;
    logic        busy;

    gpio_bcd_display #(.NDIG(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .hex6     (hex6),
        .hex7     (hex7),
        .overflow (overflow),
        .busy     (busy)
    );

`ifdef GPIO_BCD_LZB_EN
    localparam logic [6:0] B = 7'h7F;
`else
    localparam logic [6:0] B = 7'h40;
`endif

    typedef struct {
        logic [55:0] segs;
        logic        ovf;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic prev_busy = 1'b0;

    logic [55:0] hex_all;
    assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a completed conversion is a busy fall while out of reset.
    always @(negedge clk) begin
        if (rst && prev_busy && !busy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got hex=%h ovf=%b with no pending conversion", hex_all, overflow);
            end else begin
                mon_e = sb.pop_front();
                if (hex_all !== mon_e.segs || overflow !== mon_e.ovf || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL %s: got hex=%h ovf=%b cycle=%0d, expected hex=%h ovf=%b cycle=%0d",
                             mon_e.name, hex_all, overflow, cyc, mon_e.segs, mon_e.ovf, mon_e.due);
                end
            end
        end
        prev_busy = busy;
    end

    task automatic check(input string name, input logic [55:0] got, input logic [55:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [55:0] segs, input logic ovf, input int due, input string name);
        exp_t e;
        e.segs = segs;
        e.ovf  = ovf;
        e.due  = due;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d conversions still pending, got none after %0d clocks, expected 0 pending", sb.size(), n);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic convert(input logic [31:0] v, input logic [55:0] segs, input logic ovf, input string name);
        @(negedge clk);
        value = v;
        push(segs, ovf, cyc + 1 + 32, name);
        drain();
    endtask

    initial begin
        int n;
        int k;
        logic seen;

        #100000;
        $display("FAIL global_timeout: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        logic seen;

        rst   = 1'b0;
        value = '0;
        #12;
        check("reset_busy_ovf", {54'd0, busy, overflow}, 56'd0);
        check("reset_hex", hex_all, {{7{B}}, 7'h40});
        @(negedge clk);
        rst = 1'b1;

        // value equals the cleared last_q, so nothing should start.
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("idle_after_reset_busy", {55'd0, seen}, 56'd0);
        check("idle_after_reset_hex", hex_all, {{7{B}}, 7'h40});

        // 12345678 with busy width measurement.
        @(negedge clk);
        value = 32'd12345678;
        push({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 1'b0, cyc + 1 + 32, "dec_12345678");
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        check("busy_width", 56'(n), 56'd32);
        drain();

        convert(32'hFFFF_FFFF, {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}, 1'b1, "dec_ffffffff");
        convert(32'd1000,      {B, B, B, B, 7'h79, 7'h40, 7'h40, 7'h40}, 1'b0, "dec_1000");
        convert(32'd0,         {{7{B}}, 7'h40}, 1'b0, "dec_0");
        convert(32'd99999999,  {8{7'h10}}, 1'b0, "dec_99999999");
        convert(32'd100000000, {8{7'h40}}, 1'b1, "dec_100000000");

        // A glitch that reverts before the sampling edge must not start a conversion.
        @(negedge clk);
        value = 32'd7;
        #2 value = 32'd100000000;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("revert_no_conversion", {55'd0, seen}, 56'd0);

        // 99 then 5 mid-conversion: 99 at k+32, restart at k+33, 5 at k+65.
        @(negedge clk);
        value = 32'd99;
        k = cyc + 1;
        push({B, B, B, B, B, B, 7'h10, 7'h10}, 1'b0, k + 32, "dec_99_first");
        push({B, B, B, B, B, B, B, 7'h12}, 1'b0, k + 65, "dec_5_second");
        repeat (10) @(negedge clk);
        value = 32'd5;
        n = 0;
        while (cyc < k + 33 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("restart_at_k33", {55'd0, busy}, 56'd1);
        drain();

        // Asynchronous abort mid-conversion, then capture on the first edge after release.
        @(negedge clk);
        value = 32'd12345678;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy_ovf", {54'd0, busy, overflow}, 56'd0);
        check("abort_hex", hex_all, {{7{B}}, 7'h40});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 1'b0, cyc + 1 + 32, "after_abort_12345678");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
